// File: rtl/serial_neg_pkg.sv
// Shared types and helpers for the bit-serial two's-complement negator.
package serial_neg_pkg;

    // COPY: no 1 seen yet in the current word; INVERT: at least one 1 seen.
    typedef enum logic {
        COPY   = 1'b0,
        INVERT = 1'b1
    } neg_state_t;

    // Width of the in-word bit counter for a W-bit frame.
    function automatic int cnt_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/bit_skid_buffer.sv
// One-entry skid buffer: in_ready is a flop output, so there is no
// combinational path from out_ready back to in_ready.
module bit_skid_buffer #(
    parameter int DW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          full_q, full_d;
    logic [DW-1:0] data_q, data_d;

    // Park an accepted beat when the consumer refuses it; release once it is taken.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (full_q) begin
            if (out_ready) begin
                full_d = 1'b0;
            end
        end else if (in_valid && !out_ready) begin
            full_d = 1'b1;
            data_d = in_data;
        end
    end

    // Skid state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign in_ready  = ~full_q;
    assign out_valid = full_q | in_valid;
    assign out_data  = full_q ? data_q : in_data;

endmodule

// File: rtl/serial_twos_complement_negator.sv
// Bit-serial two's-complement negator, LSB first: bits are copied up to and
// including the first 1 of a word, every later bit is inverted.
// Optional build macro SERIAL_NEG_SKID_EN inserts a one-entry skid buffer so
// up_ready becomes a registered signal.
module serial_twos_complement_negator
    import serial_neg_pkg::*;
#(
    parameter int W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic up_valid,
    output logic up_ready,
    input  logic up_bit,
    output logic down_valid,
    input  logic down_ready,
    output logic down_bit,
    output logic down_last,
    output logic overflow
);

    localparam int             CW      = cnt_w(W);
    localparam logic [CW-1:0]  CNT_MAX = CW'(W - 1);

    neg_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dv_q, dv_d;
    logic          db_q, db_d;
    logic          dl_q, dl_d;
    logic          ov_q, ov_d;

    logic          up_accept;
    logic          is_last;
    logic          neg_bit;
    logic          neg_ovf;
    logic          ld_valid;
    logic          ld_ready;
    logic [2:0]    ld_data;

    assign up_accept = up_valid & up_ready;
    assign is_last   = (cnt_q == CNT_MAX);
    assign neg_bit   = (state_q == INVERT) ? ~up_bit : up_bit;
    // Only the MSB of 100..0 reaches the end still in COPY with a 1.
    assign neg_ovf   = is_last & (state_q == COPY) & up_bit;

    // Next-state and counter: advance only on an accepted up-side beat.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (up_accept) begin
            if (is_last) begin
                cnt_d   = '0;
                state_d = COPY;
            end else begin
                cnt_d = cnt_q + CW'(1);
                if ((state_q == COPY) && up_bit) begin
                    state_d = INVERT;
                end
            end
        end
    end

    // FSM state and bit counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COPY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The output register can take a beat when empty or when draining this cycle.
    assign ld_ready = ~dv_q | down_ready;

`ifdef SERIAL_NEG_SKID_EN
    bit_skid_buffer #(
        .DW (3)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (up_valid),
        .in_ready  (up_ready),
        .in_data   ({neg_bit, is_last, neg_ovf}),
        .out_valid (ld_valid),
        .out_ready (ld_ready),
        .out_data  (ld_data)
    );
`else
    assign up_ready = ld_ready;
    assign ld_valid = up_valid;
    assign ld_data  = {neg_bit, is_last, neg_ovf};
`endif

    // Output register: reload on a new beat, clear valid once emitted, else hold.
    always_comb begin
        dv_d = dv_q;
        db_d = db_q;
        dl_d = dl_q;
        ov_d = ov_q;
        if (ld_valid && ld_ready) begin
            dv_d = 1'b1;
            db_d = ld_data[2];
            dl_d = ld_data[1];
            ov_d = ld_data[0];
        end else if (dv_q && down_ready) begin
            dv_d = 1'b0;
        end
    end

    // Output register flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_q <= 1'b0;
            db_q <= 1'b0;
            dl_q <= 1'b0;
            ov_q <= 1'b0;
        end else begin
            dv_q <= dv_d;
            db_q <= db_d;
            dl_q <= dl_d;
            ov_q <= ov_d;
        end
    end

    assign down_valid = dv_q;
    assign down_bit   = db_q;
    assign down_last  = dl_q;
    assign overflow   = ov_q;

endmodule

// File: tb/tb_serial_twos_complement_negator.sv
// Directed bench for serial_twos_complement_negator with a scoreboard of
// expected output beats derived from arithmetic negation of each word.
module tb_serial_twos_complement_negator;

    localparam int W = 8;

    typedef struct packed {
        logic b;
        logic l;
        logic o;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic up_valid = 1'b0;
    logic up_bit = 1'b0;
    logic down_ready = 1'b1;
    logic up_ready;
    logic down_valid;
    logic down_bit;
    logic down_last;
    logic overflow;

    exp_t q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;
    int   lasts_seen = 0;
    bit   check_lat = 1'b0;

    serial_twos_complement_negator #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_bit     (up_bit),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_bit   (down_bit),
        .down_last  (down_last),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Output monitor: every emitted beat is checked against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && down_valid && down_ready) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $error("FAIL unexpected_beat: got bit %b last %b, none expected", down_bit, down_last);
            end else begin
                mon_e = q.pop_front();
                assert ({down_bit, down_last, overflow} === {mon_e.b, mon_e.l, mon_e.o}) else begin
                    miscompares++;
                    $error("FAIL beat: got bit/last/ovf %b%b%b want %b%b%b",
                           down_bit, down_last, overflow, mon_e.b, mon_e.l, mon_e.o);
                end
                if (down_last === 1'b1) lasts_seen++;
            end
        end
    end

    task automatic check_bit(input string tag, input logic got, input logic exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %b want %b", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    // Present one bit and hold it until accepted; push its expected output beat.
    task automatic send_bit(input logic b, input exp_t e, input bit rand_ready);
        bit done = 1'b0;
        int waited = 0;
        up_valid = 1'b1;
        up_bit   = b;
        while (!done && waited < 64) begin
            @(negedge clk);
            if (up_ready === 1'b1) begin
                q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            waited++;
            if (rand_ready) down_ready = 1'($urandom_range(0, 1));
        end
        if (!done) check_int("accept_timeout", waited, -1);
        if (check_lat) begin
            check_bit("latency_valid", down_valid, 1'b1);
            check_bit("latency_bit", down_bit, e.b);
        end
    endtask

    // Send one word LSB first; stall_mask[i] holds output beat i for two cycles.
    task automatic send_word(input logic [W-1:0] w, input logic [W-1:0] stall_mask,
                             input bit rand_ready);
        logic [W-1:0] n;
        exp_t e;
        n = -w;
        for (int i = 0; i < W; i++) begin
            e.b = n[i];
            e.l = (i == W - 1);
            e.o = (i == W - 1) && (w == {1'b1, {(W-1){1'b0}}});
            send_bit(w[i], e, rand_ready);
            if (stall_mask[i]) begin
                up_valid   = 1'b0;
                down_ready = 1'b0;
                repeat (2) begin
                    @(negedge clk);
`ifndef SERIAL_NEG_SKID_EN
                    check_bit("stall_up_ready", up_ready, 1'b0);
`endif
                    check_bit("stall_hold_valid", down_valid, 1'b1);
                    check_bit("stall_hold_bit", down_bit, e.b);
                    @(posedge clk);
                    #1;
                end
                down_ready = 1'b1;
            end
        end
    endtask

    task automatic drain();
        int k = 0;
        up_valid   = 1'b0;
        down_ready = 1'b1;
        while (q.size() != 0 && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        check_int("drain_empty", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] rw;
        logic [W-1:0] part;
        exp_t pe;
        logic ur_before;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_bit("rst_down_valid", down_valid, 1'b0);
        check_bit("rst_down_bit", down_bit, 1'b0);
        check_bit("rst_down_last", down_last, 1'b0);
        check_bit("rst_overflow", overflow, 1'b0);
        check_bit("rst_up_ready", up_ready, 1'b1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 0x06 -> 0xFA, one-cycle latency per bit
        check_lat = 1'b1;
        send_word(8'h06, 8'h00, 1'b0);
        check_lat = 1'b0;
        drain();
        check_int("lasts_0x06", lasts_seen, 1);

        // Most-negative word flags overflow; zero word stays zero
        send_word(8'h80, 8'h00, 1'b0);
        send_word(8'h00, 8'h00, 1'b0);
        drain();
        check_int("lasts_0x80_0x00", lasts_seen, 3);

        // Output stalled on beats 3..5
        send_word(8'h06, 8'b0001_1100, 1'b0);
        drain();
        check_int("lasts_stall", lasts_seen, 4);

        // Back-to-back words, second starts in COPY
        send_word(8'h01, 8'h00, 1'b0);
        send_word(8'h7F, 8'h00, 1'b0);
        drain();
        check_int("lasts_b2b", lasts_seen, 6);

        // Reset mid-word after 3 accepted bits
        part = 8'h06;
        rw   = -part;
        for (int i = 0; i < 3; i++) begin
            pe.b = rw[i];
            pe.l = 1'b0;
            pe.o = 1'b0;
            send_bit(part[i], pe, 1'b0);
        end
        up_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check_bit("midrst_down_valid", down_valid, 1'b0);
        check_bit("midrst_down_bit", down_bit, 1'b0);
        check_bit("midrst_down_last", down_last, 1'b0);
        check_bit("midrst_overflow", overflow, 1'b0);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_word(8'h03, 8'h00, 1'b0);
        drain();
        check_int("lasts_after_reset", lasts_seen, 7);

        // Random data with random down_ready
        void'($urandom(32'd20240611));
        for (int k = 0; k < 16; k++) begin
            rw = 8'($urandom_range(0, 255));
            send_word(rw, 8'h00, 1'b1);
        end
        drain();
        check_int("lasts_random", lasts_seen, 23);

`ifdef SERIAL_NEG_SKID_EN
        // up_ready must not follow down_ready within a cycle
        up_valid   = 1'b0;
        down_ready = 1'b1;
        #1;
        ur_before = up_ready;
        down_ready = 1'b0;
        #1;
        check_bit("up_ready_no_comb_path", up_ready, ur_before);
        down_ready = 1'b1;
        @(posedge clk);
        #1;
`else
        ur_before = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
